// File: rtl/shifter_pipe_if.sv
// Handshake bundle for shifter_pipe: operand side (in_*) and result side (out_*).
// The master modport is the producer/consumer around the shifter, slave is the shifter.
interface shifter_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int CW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    in_cnt;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one register stage per count bit (LSB first),
// global stall from the result side, rotate/shift/pass-through ops.
module shifter_pipe #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  shifter_pipe_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  logic             valid_r [CW];
  logic [WIDTH-1:0] data_r  [CW];
  logic [2:0]       op_r    [CW];
  logic [CW-1:0]    cnt_r   [CW];
  logic             sign_r  [CW];

  logic             stg_valid_s [CW];
  logic [WIDTH-1:0] stg_data_s  [CW];
  logic [2:0]       stg_op_s    [CW];
  logic [CW-1:0]    stg_cnt_s   [CW];
  logic             stg_sign_s  [CW];
  logic             stall_s;

  // Arithmetic fill uses the sign captured at accept, not the current MSB.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                  input logic [2:0]       op,
                                                  input logic             sign,
                                                  input int               amt);
    logic [WIDTH-1:0] fill;
    fill = sign ? ~({WIDTH{1'b1}} >> amt) : {WIDTH{1'b0}};
    case (op)
      OP_ROL:  shift_step = (d << amt) | (d >> (WIDTH - amt));
      OP_SLL:  shift_step = d << amt;
      OP_SRA:  shift_step = (d >> amt) | fill;
      OP_SRL:  shift_step = d >> amt;
      OP_ROR:  shift_step = (d >> amt) | (d << (WIDTH - amt));
      default: shift_step = d;
    endcase
  endfunction

  assign stall_s       = valid_r[CW-1] && !bus.out_ready;
  assign bus.in_ready  = !stall_s;
  assign bus.out_valid = valid_r[CW-1];
  assign bus.out_data  = data_r[CW-1];
  assign bus.out_zero  = (data_r[CW-1] == {WIDTH{1'b0}});

  // Stage inputs: the operand port feeds stage 0, each later stage its predecessor.
  always_comb begin
    stg_valid_s[0] = bus.in_valid;
    stg_data_s[0]  = bus.in_data;
    stg_op_s[0]    = bus.in_op;
    stg_cnt_s[0]   = bus.in_cnt;
    stg_sign_s[0]  = bus.in_data[WIDTH-1];
    for (int k = 1; k < CW; k++) begin
      stg_valid_s[k] = valid_r[k-1];
      stg_data_s[k]  = data_r[k-1];
      stg_op_s[k]    = op_r[k-1];
      stg_cnt_s[k]   = cnt_r[k-1];
      stg_sign_s[k]  = sign_r[k-1];
    end
  end

  // All stages advance together; the count is shifted down so bit 0 is always the live bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CW; k++) begin
        valid_r[k] <= 1'b0;
        data_r[k]  <= {WIDTH{1'b0}};
        op_r[k]    <= 3'b000;
        cnt_r[k]   <= {CW{1'b0}};
        sign_r[k]  <= 1'b0;
      end
    end else if (!stall_s) begin
      for (int k = 0; k < CW; k++) begin
        valid_r[k] <= stg_valid_s[k];
        data_r[k]  <= stg_cnt_s[k][0]
                      ? shift_step(stg_data_s[k], stg_op_s[k], stg_sign_s[k], 32'd1 << k)
                      : stg_data_s[k];
        op_r[k]    <= stg_op_s[k];
        cnt_r[k]   <= stg_cnt_s[k] >> 1'b1;
        sign_r[k]  <= stg_sign_s[k];
      end
    end
  end
endmodule
